// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction fetch front end with a small prefetch queue.
// Issues sequential word fetches to instruction memory and buffers the returned
// instructions with their PCs. The buffered head is presented to IF_ID under a
// valid/ready handshake. A redirect flushes the queue, discards every response
// still in flight, and restarts fetching at the new target.
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp,
  input  logic [31:0] jmp_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] cur_pc_o,
  output logic [31:0] cur_inst_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = CW + OW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];

  logic [SW-1:0] in_use;
  logic          accept;
  logic          rsp_ok;
  logic          pop;
  logic          push;

  // Request only while both credits remain: the outstanding limit and enough
  // room in the queue for every live (non-discarded) response plus what is held.
  always_comb begin
    in_use     = SW'(cnt_q) + SW'(out_cnt_q - drop_cnt_q);
    imem_req_o = !rst && !jmp && (out_cnt_q < OW'(MAX_OUT)) && (in_use < SW'(DEPTH));
  end

  assign imem_addr_o = fetch_pc_q;
  assign accept      = imem_req_o && imem_req_ready_i;
  assign rsp_ok      = imem_rsp_valid_i && (out_cnt_q != '0);

  // Head of queue comes straight from storage, so responses never reach IF_ID
  // combinationally; an empty queue shows PC 0 and a NOP.
  always_comb begin
    inst_valid_o = (cnt_q != '0) && !jmp;
    pop          = inst_valid_o && inst_ready_i;
    cur_pc_o     = (cnt_q != '0) ? pc_mem_q[rd_ptr_q] : 32'h0;
    cur_inst_o   = (cnt_q != '0) ? inst_mem_q[rd_ptr_q] : NOP;
  end

  // Next-state: redirect overrides everything, otherwise fetch advance,
  // response push/discard and head pop proceed independently.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    out_cnt_d  = out_cnt_q + OW'(accept) - OW'(rsp_ok);
    drop_cnt_d = drop_cnt_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    push       = 1'b0;

    if (jmp) begin
      fetch_pc_d = jmp_pc_i & ~32'h3;
      rsp_pc_d   = jmp_pc_i & ~32'h3;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Every request still in flight after this cycle is stale. Ones already
      // marked for discard are among them, so the new discard count is simply
      // what remains outstanding; this keeps repeated redirects exact.
      drop_cnt_d = out_cnt_q - OW'(rsp_ok);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_ok) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - OW'(1);
        end else begin
          push = 1'b1;
        end
      end
      if (push) begin
        pc_mem_d[wr_ptr_q]   = rsp_pc_q;
        inst_mem_d[wr_ptr_q] = imem_rsp_data_i;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        rsp_pc_d             = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: randomized bench for inst_prefetch. An in-bench memory model
// answers fetches in order after a chosen latency; the reference model says the
// consumed stream is word-sequential from the last redirect target, with data
// being a fixed function of the address.
module tb_inst_prefetch;

  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        jmp;
  logic [31:0] jmp_pc;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid_o;
  logic        inst_ready;
  logic [31:0] cur_pc_o;
  logic [31:0] cur_inst_o;

  inst_prefetch #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .jmp              (jmp),
    .jmp_pc_i         (jmp_pc),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_req_ready_i (req_ready),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready),
    .cur_pc_o         (cur_pc_o),
    .cur_inst_o       (cur_inst_o)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend_q[$];
  int          checks;
  int          failures;
  int          cyc;
  int          lat;
  int          ready_pct;
  int          irdy_pct;
  int          tb_out;
  int          tb_queued;
  bit          exp_req;
  logic [31:0] exp_pc;
  logic        obs_req;
  logic        obs_acc;
  logic        obs_pop;
  logic        obs_valid;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc;
  logic [31:0] obs_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Safety net so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    jmp        = 1'b0;
    jmp_pc     = 32'h0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = 32'h0;
    inst_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    pend_q.delete();
    tb_out    = 0;
    tb_queued = 0;
    cyc       = 0;
    exp_pc    = 32'h0;
  endtask

  // One clock cycle: drive inputs at the falling edge, sample outputs just after,
  // work out the model's view of the coming edge, then wait for that edge.
  task automatic cycle(input bit j, input logic [31:0] tgt);
    int stale_n;
    bit was_stale;
    pend_t e;
    @(negedge clk);
    rst        = 1'b0;
    jmp        = j;
    jmp_pc     = tgt;
    req_ready  = ($urandom_range(99) < ready_pct);
    inst_ready = ($urandom_range(99) < irdy_pct);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend_q[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    #1;
    stale_n = 0;
    for (int i = 0; i < pend_q.size(); i++) if (pend_q[i].stale) stale_n++;
    exp_req   = !j && (tb_out < MAX_OUT) && ((tb_queued + tb_out - stale_n) < DEPTH);
    obs_req   = imem_req_o;
    obs_addr  = imem_addr_o;
    obs_valid = inst_valid_o;
    obs_acc   = imem_req_o && req_ready;
    obs_pop   = inst_valid_o && inst_ready;
    obs_pc    = cur_pc_o;
    obs_inst  = cur_inst_o;
    was_stale = 1'b0;
    if (rsp_valid) begin
      was_stale = pend_q[0].stale;
      void'(pend_q.pop_front());
      tb_out--;
    end
    if (j) begin
      tb_queued = 0;
      for (int i = 0; i < pend_q.size(); i++) pend_q[i].stale = 1'b1;
    end else begin
      if (rsp_valid && !was_stale) tb_queued++;
      if (obs_pop) tb_queued--;
    end
    if (obs_acc) begin
      e.addr  = imem_addr_o;
      e.due   = cyc + lat;
      e.stale = 1'b0;
      pend_q.push_back(e);
      tb_out++;
    end
    cyc++;
    @(posedge clk);
  endtask

  // Reset state, both at start-up and when reset hits a busy queue.
  task automatic test_reset();
    lat = 1; ready_pct = 100; irdy_pct = 0;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      @(negedge clk);
      #1;
      checks++;
      if (imem_req_o !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_req pass %0d got %b want 0", pass, imem_req_o);
      end
      checks++;
      if (inst_valid_o !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_valid pass %0d got %b want 0", pass, inst_valid_o);
      end
      checks++;
      if (cur_pc_o !== 32'h0) begin
        failures++; $display("[TB] FAIL reset_pc pass %0d got %h want 0", pass, cur_pc_o);
      end
      checks++;
      if (cur_inst_o !== NOP) begin
        failures++; $display("[TB] FAIL reset_inst pass %0d got %h want %h", pass, cur_inst_o, NOP);
      end
      repeat (6) cycle(1'b0, 32'h0);
    end
  endtask

  // Zero-wait memory: one fetch per cycle from 0, first instruction in cycle 2.
  task automatic test_startup();
    do_reset();
    lat = 1; ready_pct = 100; irdy_pct = 100;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 32'h0);
      checks++;
      if (obs_valid !== (k >= 2)) begin
        failures++; $display("[TB] FAIL startup_valid cycle %0d got %b want %b", k, obs_valid, (k >= 2));
      end
      checks++;
      if (obs_acc !== 1'b1 || obs_addr !== 32'(4 * k)) begin
        failures++; $display("[TB] FAIL startup_addr cycle %0d got acc=%b addr=%h want acc=1 addr=%h", k, obs_acc, obs_addr, 32'(4 * k));
      end
      if (obs_pop) begin
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== mem_word(exp_pc)) begin
          failures++; $display("[TB] FAIL startup_pop got pc=%h inst=%h want pc=%h inst=%h", obs_pc, obs_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  // IF_ID stalled: queue fills to DEPTH, requests stop, then drains in order.
  task automatic test_backpressure();
    int accepts;
    int pops;
    do_reset();
    lat = 1; ready_pct = 100; irdy_pct = 0;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0);
      if (obs_acc) accepts++;
    end
    checks++;
    if (accepts !== DEPTH) begin
      failures++; $display("[TB] FAIL hold_accepts got %0d want %0d", accepts, DEPTH);
    end
    checks++;
    if (obs_req !== 1'b0) begin
      failures++; $display("[TB] FAIL hold_req got %b want 0", obs_req);
    end
    checks++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
      failures++; $display("[TB] FAIL hold_head got valid=%b pc=%h want valid=1 pc=0", obs_valid, obs_pc);
    end
    irdy_pct = 100;
    pops = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 32'h0);
      if (obs_pop) begin
        pops++;
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== mem_word(exp_pc)) begin
          failures++; $display("[TB] FAIL drain_pop got pc=%h inst=%h want pc=%h inst=%h", obs_pc, obs_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++;
    if (pops < 8) begin
      failures++; $display("[TB] FAIL drain_count got %0d want at least 8", pops);
    end
  endtask

  // Slow memory: outstanding requests bounded, request issued whenever credit allows.
  task automatic test_latency();
    do_reset();
    lat = 3; ready_pct = 80; irdy_pct = 100;
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, 32'h0);
      checks++;
      if (obs_req !== exp_req) begin
        failures++; $display("[TB] FAIL lat_req cycle %0d got %b want %b", k, obs_req, exp_req);
      end
      checks++;
      if (tb_out > MAX_OUT) begin
        failures++; $display("[TB] FAIL lat_outstanding cycle %0d got %0d want <= %0d", k, tb_out, MAX_OUT);
      end
      if (obs_pop) begin
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== mem_word(exp_pc)) begin
          failures++; $display("[TB] FAIL lat_pop got pc=%h inst=%h want pc=%h inst=%h", obs_pc, obs_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++;
    if (exp_pc < 32'h20) begin
      failures++; $display("[TB] FAIL lat_progress got next pc %h want at least 20", exp_pc);
    end
  endtask

  // Redirect with two requests in flight: both responses discarded.
  task automatic test_jmp();
    int n;
    bit got;
    do_reset();
    lat = 3; ready_pct = 100; irdy_pct = 100;
    n = 0;
    while (tb_out < 2 && n < 20) begin
      cycle(1'b0, 32'h0);
      n++;
    end
    checks++;
    if (tb_out != 2) begin
      failures++; $display("[TB] FAIL jmp_setup outstanding got %0d want 2", tb_out);
    end
    cycle(1'b1, 32'h100);
    checks++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
      failures++; $display("[TB] FAIL jmp_cycle got valid=%b req=%b want 0 0", obs_valid, obs_req);
    end
    exp_pc = 32'h100;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      cycle(1'b0, 32'h0);
      if (obs_pop) begin
        got = 1'b1;
        checks++;
        if (obs_pc !== 32'h100 || obs_inst !== mem_word(32'h100)) begin
          failures++; $display("[TB] FAIL jmp_first got pc=%h inst=%h want pc=100 inst=%h", obs_pc, obs_inst, mem_word(32'h100));
        end
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("[TB] FAIL jmp_timeout got no instruction want pc=100 within 40 cycles");
    end
  endtask

  // Two redirects in a row: only the second target's stream may appear.
  task automatic test_back_to_back();
    bit first_acc;
    int pops;
    do_reset();
    lat = 3; ready_pct = 100; irdy_pct = 100;
    cycle(1'b0, 32'h0);
    cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h300);
    checks++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_jmp1 got valid=%b req=%b want 0 0", obs_valid, obs_req);
    end
    cycle(1'b1, 32'h402);
    exp_pc = 32'h400;
    first_acc = 1'b1;
    pops = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(1'b0, 32'h0);
      checks++;
      if (obs_req !== exp_req) begin
        failures++; $display("[TB] FAIL b2b_req cycle %0d got %b want %b", k, obs_req, exp_req);
      end
      if (obs_acc && first_acc) begin
        first_acc = 1'b0;
        checks++;
        if (obs_addr !== 32'h400) begin
          failures++; $display("[TB] FAIL b2b_addr got %h want 400", obs_addr);
        end
      end
      if (obs_pop) begin
        pops++;
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== mem_word(exp_pc)) begin
          failures++; $display("[TB] FAIL b2b_pop got pc=%h inst=%h want pc=%h inst=%h", obs_pc, obs_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++;
    if (pops < 8) begin
      failures++; $display("[TB] FAIL b2b_count got %0d want at least 8", pops);
    end
  endtask

  // Redirect to an unaligned target while a response arrives and IF_ID is ready.
  task automatic test_jmp_collide();
    bit got;
    do_reset();
    lat = 1; ready_pct = 100; irdy_pct = 100;
    repeat (6) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h203);
    checks++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
      failures++; $display("[TB] FAIL collide_jmp got valid=%b req=%b want 0 0", obs_valid, obs_req);
    end
    cycle(1'b0, 32'h0);
    checks++;
    if (obs_acc !== 1'b1 || obs_addr !== 32'h200) begin
      failures++; $display("[TB] FAIL collide_addr got acc=%b addr=%h want acc=1 addr=200", obs_acc, obs_addr);
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle(1'b0, 32'h0);
      if (obs_pop) begin
        got = 1'b1;
        checks++;
        if (obs_pc !== 32'h200 || obs_inst !== mem_word(32'h200)) begin
          failures++; $display("[TB] FAIL collide_first got pc=%h inst=%h want pc=200 inst=%h", obs_pc, obs_inst, mem_word(32'h200));
        end
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("[TB] FAIL collide_timeout got no instruction want pc=200 within 10 cycles");
    end
  endtask

  // Fetching across the top of the address space wraps to zero.
  task automatic test_wrap();
    logic [31:0] acc_q[$];
    logic [31:0] want;
    int pops;
    do_reset();
    lat = 1; ready_pct = 100; irdy_pct = 100;
    cycle(1'b1, 32'hFFFF_FFF8);
    exp_pc = 32'hFFFF_FFF8;
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0);
      if (obs_acc) acc_q.push_back(obs_addr);
      if (obs_pop) begin
        pops++;
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== mem_word(exp_pc)) begin
          failures++; $display("[TB] FAIL wrap_pop got pc=%h inst=%h want pc=%h inst=%h", obs_pc, obs_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    for (int i = 0; i < 3; i++) begin
      want = 32'hFFFF_FFF8 + 32'(4 * i);
      checks++;
      if (acc_q.size() <= i) begin
        failures++; $display("[TB] FAIL wrap_addr%0d got none want %h", i, want);
      end else if (acc_q[i] !== want) begin
        failures++; $display("[TB] FAIL wrap_addr%0d got %h want %h", i, acc_q[i], want);
      end
    end
    checks++;
    if (pops < 4) begin
      failures++; $display("[TB] FAIL wrap_count got %0d want at least 4", pops);
    end
  endtask

  // Long random run: random memory timing, stalls and redirects (some back to back).
  task automatic test_random();
    bit          j;
    bit          prev_j;
    logic [31:0] tgt;
    int          pops;
    do_reset();
    ready_pct = 70; irdy_pct = 60;
    prev_j = 1'b0;
    pops = 0;
    for (int k = 0; k < 600; k++) begin
      lat = $urandom_range(1, 4);
      j   = ($urandom_range(15) == 0) || (prev_j && $urandom_range(1) == 0);
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle(j, tgt);
      checks++;
      if (obs_req !== exp_req) begin
        failures++; $display("[TB] FAIL rnd_req cycle %0d got %b want %b", k, obs_req, exp_req);
      end
      checks++;
      if (tb_out > MAX_OUT || tb_queued > DEPTH) begin
        failures++; $display("[TB] FAIL rnd_credit cycle %0d got out=%0d queued=%0d want <= %0d and <= %0d", k, tb_out, tb_queued, MAX_OUT, DEPTH);
      end
      if (j) begin
        checks++;
        if (obs_valid !== 1'b0) begin
          failures++; $display("[TB] FAIL rnd_jmp_valid cycle %0d got %b want 0", k, obs_valid);
        end
        exp_pc = tgt & ~32'h3;
      end else if (obs_pop) begin
        pops++;
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== mem_word(exp_pc)) begin
          failures++; $display("[TB] FAIL rnd_pop cycle %0d got pc=%h inst=%h want pc=%h inst=%h", k, obs_pc, obs_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      prev_j = j;
    end
    checks++;
    if (pops < 100) begin
      failures++; $display("[TB] FAIL rnd_progress got %0d pops want at least 100", pops);
    end
  endtask

  // Test sequence and summary.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    jmp      = 1'b0;
    jmp_pc   = 32'h0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = 32'h0;
    inst_ready = 1'b0;
    lat = 1; ready_pct = 100; irdy_pct = 100;
    test_reset();
    test_startup();
    test_backpressure();
    test_latency();
    test_jmp();
    test_back_to_back();
    test_jmp_collide();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
